// File: rtl/qick_net_rx_deframer.sv
// Receive-side deframer for one qick_net link: checks framing and checksum of 3-beat
// command packets, routes them local/forward and queues them for the tProc side.
module qick_net_rx_deframer #(
    parameter int         FIFO_DEPTH = 4,
    parameter int         CNT_W      = 16,
    parameter logic [4:0] BCAST_ID   = 5'h1F
) (
    input  logic             c_clk_i,
    input  logic             c_rst_i,
    input  logic [4:0]       my_id_i,
    input  logic             rx_tvalid_i,
    input  logic [63:0]      rx_tdata_i,
    input  logic             rx_tlast_i,
    output logic             pkt_valid_o,
    input  logic             pkt_ready_i,
    output logic [4:0]       pkt_op_o,
    output logic [4:0]       pkt_src_o,
    output logic [4:0]       pkt_hop_o,
    output logic [31:0]      pkt_dt1_o,
    output logic [31:0]      pkt_dt2_o,
    output logic [31:0]      pkt_dt3_o,
    output logic [47:0]      pkt_time_o,
    output logic             pkt_local_o,
    output logic             pkt_fwd_o,
    input  logic             clr_cnt_i,
    output logic [CNT_W-1:0] cnt_ok_o,
    output logic [CNT_W-1:0] cnt_frm_err_o,
    output logic [CNT_W-1:0] cnt_sum_err_o,
    output logic [CNT_W-1:0] cnt_drop_o
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {S_IDLE, S_W1, S_W2, S_DISCARD} state_t;

    typedef struct packed {
        logic [4:0]  op;
        logic [4:0]  src;
        logic [4:0]  hop;
        logic [31:0] dt1;
        logic [31:0] dt2;
        logic [31:0] dt3;
        logic [47:0] tstamp;
        logic        is_local;
        logic        is_fwd;
    } entry_t;

    function automatic logic [15:0] lane_xor(input logic [63:0] w);
        return w[63:48] ^ w[47:32] ^ w[31:16] ^ w[15:0];
    endfunction

    function automatic logic [CNT_W-1:0] cnt_next(input logic [CNT_W-1:0] c,
                                                   input logic inc, input logic clr);
        if (clr)
            return '0;
        if (inc && (c != '1))
            return c + CNT_W'(1);
        return c;
    endfunction

    state_t            state_q, state_d;
    logic [15:0]       csum_q, csum_d;
    logic [4:0]        op_q, op_d, dst_q, dst_d, src_q, src_d, hop_q, hop_d;
    logic [31:0]       dt1_q, dt1_d, dt2_q, dt2_d, dt3_q, dt3_d;
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic [CNT_W-1:0]  ok_q, ok_d, frm_q, frm_d, sum_q, sum_d, drop_q, drop_d;
    entry_t            mem_q [FIFO_DEPTH];
    entry_t            entry_d, head;

    logic frm_inc, sum_inc, route_drop, push_req, push_ok, pop, full;
    logic local_w, fwd_w;

    assign local_w = (dst_q == my_id_i) | (dst_q == BCAST_ID);
    assign fwd_w   = (dst_q != my_id_i) & (hop_q != 5'h1F);
    assign full    = (count_q == CW'(FIFO_DEPTH));
    assign pop     = pkt_valid_o & pkt_ready_i;
    assign push_ok = push_req & (!full | pop);

    always_comb begin
        state_d    = state_q;
        csum_d     = csum_q;
        op_d       = op_q;
        dst_d      = dst_q;
        src_d      = src_q;
        hop_d      = hop_q;
        dt1_d      = dt1_q;
        dt2_d      = dt2_q;
        dt3_d      = dt3_q;
        frm_inc    = 1'b0;
        sum_inc    = 1'b0;
        route_drop = 1'b0;
        push_req   = 1'b0;
        if (rx_tvalid_i) begin
            case (state_q)
                S_IDLE: begin
                    if (rx_tdata_i[63:60] != 4'hA) begin
                        frm_inc = 1'b1;
                        state_d = rx_tlast_i ? S_IDLE : S_DISCARD;
                    end else if (rx_tlast_i) begin
                        frm_inc = 1'b1;
                    end else begin
                        op_d    = rx_tdata_i[59:55];
                        dst_d   = rx_tdata_i[54:50];
                        src_d   = rx_tdata_i[49:45];
                        hop_d   = rx_tdata_i[44:40];
                        dt1_d   = rx_tdata_i[31:0];
                        csum_d  = lane_xor(rx_tdata_i);
                        state_d = S_W1;
                    end
                end
                S_W1: begin
                    if (rx_tlast_i) begin
                        frm_inc = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        dt2_d   = rx_tdata_i[63:32];
                        dt3_d   = rx_tdata_i[31:0];
                        csum_d  = csum_q ^ lane_xor(rx_tdata_i);
                        state_d = S_W2;
                    end
                end
                S_W2: begin
                    if (!rx_tlast_i) begin
                        frm_inc = 1'b1;
                        state_d = S_DISCARD;
                    end else begin
                        state_d = S_IDLE;
                        // The checksum lane itself is zeroed so only the 48-bit timestamp folds in.
                        if ((csum_q ^ lane_xor({rx_tdata_i[63:16], 16'h0})) != rx_tdata_i[15:0])
                            sum_inc = 1'b1;
                        else if ((src_q == my_id_i) || (!local_w && !fwd_w))
                            route_drop = 1'b1;
                        else
                            push_req = 1'b1;
                    end
                end
                default: begin
                    if (rx_tlast_i)
                        state_d = S_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        entry_d.op       = op_q;
        entry_d.src      = src_q;
        entry_d.hop      = fwd_w ? hop_q + 5'd1 : hop_q;
        entry_d.dt1      = dt1_q;
        entry_d.dt2      = dt2_q;
        entry_d.dt3      = dt3_q;
        entry_d.tstamp   = rx_tdata_i[63:16];
        entry_d.is_local = local_w;
        entry_d.is_fwd   = fwd_w;

        wr_ptr_d = push_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop     ? rd_ptr_q + AW'(1) : rd_ptr_q;
        case ({push_ok, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        ok_d   = cnt_next(ok_q,   push_ok,                            clr_cnt_i);
        frm_d  = cnt_next(frm_q,  frm_inc,                            clr_cnt_i);
        sum_d  = cnt_next(sum_q,  sum_inc,                            clr_cnt_i);
        drop_d = cnt_next(drop_q, route_drop | (push_req & !push_ok), clr_cnt_i);
    end

    always_ff @(posedge c_clk_i) begin
        if (c_rst_i) begin
            state_q  <= S_IDLE;
            csum_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ok_q     <= '0;
            frm_q    <= '0;
            sum_q    <= '0;
            drop_q   <= '0;
        end else begin
            state_q  <= state_d;
            csum_q   <= csum_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ok_q     <= ok_d;
            frm_q    <= frm_d;
            sum_q    <= sum_d;
            drop_q   <= drop_d;
        end
    end

    // Packet fields and FIFO storage carry no reset; the valid gating below hides them.
    always_ff @(posedge c_clk_i) begin
        op_q  <= op_d;
        dst_q <= dst_d;
        src_q <= src_d;
        hop_q <= hop_d;
        dt1_q <= dt1_d;
        dt2_q <= dt2_d;
        dt3_q <= dt3_d;
        if (push_ok)
            mem_q[wr_ptr_q] <= entry_d;
    end

    assign head        = mem_q[rd_ptr_q];
    assign pkt_valid_o = (count_q != '0);
    assign pkt_op_o    = pkt_valid_o ? head.op       : '0;
    assign pkt_src_o   = pkt_valid_o ? head.src      : '0;
    assign pkt_hop_o   = pkt_valid_o ? head.hop      : '0;
    assign pkt_dt1_o   = pkt_valid_o ? head.dt1      : '0;
    assign pkt_dt2_o   = pkt_valid_o ? head.dt2      : '0;
    assign pkt_dt3_o   = pkt_valid_o ? head.dt3      : '0;
    assign pkt_time_o  = pkt_valid_o ? head.tstamp   : '0;
    assign pkt_local_o = pkt_valid_o & head.is_local;
    assign pkt_fwd_o   = pkt_valid_o & head.is_fwd;

    assign cnt_ok_o      = ok_q;
    assign cnt_frm_err_o = frm_q;
    assign cnt_sum_err_o = sum_q;
    assign cnt_drop_o    = drop_q;

endmodule

// File: tb/tb_qick_net_rx_deframer.sv
// Directed bench for qick_net_rx_deframer: expected packets go into a scoreboard queue,
// a negedge monitor compares each one the DUT hands over.
module tb_qick_net_rx_deframer;

    logic        c_clk_i = 1'b0;
    logic        c_rst_i = 1'b1;
    logic [4:0]  my_id_i = 5'd3;
    logic        rx_tvalid_i = 1'b0;
    logic [63:0] rx_tdata_i = '0;
    logic        rx_tlast_i = 1'b0;
    logic        pkt_valid_o;
    logic        pkt_ready_i = 1'b1;
    logic [4:0]  pkt_op_o, pkt_src_o, pkt_hop_o;
    logic [31:0] pkt_dt1_o, pkt_dt2_o, pkt_dt3_o;
    logic [47:0] pkt_time_o;
    logic        pkt_local_o, pkt_fwd_o;
    logic        clr_cnt_i = 1'b0;
    logic [15:0] cnt_ok_o, cnt_frm_err_o, cnt_sum_err_o, cnt_drop_o;

    qick_net_rx_deframer #(.FIFO_DEPTH(4), .CNT_W(16), .BCAST_ID(5'h1F)) dut (
        .c_clk_i(c_clk_i), .c_rst_i(c_rst_i), .my_id_i(my_id_i),
        .rx_tvalid_i(rx_tvalid_i), .rx_tdata_i(rx_tdata_i), .rx_tlast_i(rx_tlast_i),
        .pkt_valid_o(pkt_valid_o), .pkt_ready_i(pkt_ready_i),
        .pkt_op_o(pkt_op_o), .pkt_src_o(pkt_src_o), .pkt_hop_o(pkt_hop_o),
        .pkt_dt1_o(pkt_dt1_o), .pkt_dt2_o(pkt_dt2_o), .pkt_dt3_o(pkt_dt3_o),
        .pkt_time_o(pkt_time_o), .pkt_local_o(pkt_local_o), .pkt_fwd_o(pkt_fwd_o),
        .clr_cnt_i(clr_cnt_i), .cnt_ok_o(cnt_ok_o), .cnt_frm_err_o(cnt_frm_err_o),
        .cnt_sum_err_o(cnt_sum_err_o), .cnt_drop_o(cnt_drop_o)
    );

    always #5 c_clk_i = ~c_clk_i;

    typedef struct packed {
        logic [4:0]  op;
        logic [4:0]  src;
        logic [4:0]  hop;
        logic [31:0] dt1;
        logic [31:0] dt2;
        logic [31:0] dt3;
        logic [47:0] tstamp;
        logic        is_local;
        logic        is_fwd;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   e_ok = 0, e_frm = 0, e_sum = 0, e_drop = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: a transfer happens on the next rising edge when valid & ready at negedge.
    always @(negedge c_clk_i) begin
        if (!c_rst_i && pkt_valid_o && pkt_ready_i) begin
            if (sb.size() == 0) begin
                check("unexpected_pkt", {32'h0, pkt_dt1_o}, 64'hDEAD_BEEF_DEAD_BEEF);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("pkt_dt1", {32'h0, pkt_dt1_o}, {32'h0, e.dt1});
                check("pkt_dt2", {32'h0, pkt_dt2_o}, {32'h0, e.dt2});
                check("pkt_dt3", {32'h0, pkt_dt3_o}, {32'h0, e.dt3});
                check("pkt_time", {16'h0, pkt_time_o}, {16'h0, e.tstamp});
                check("pkt_op_src_hop_loc_fwd",
                      {47'h0, pkt_op_o, pkt_src_o, pkt_hop_o, pkt_local_o, pkt_fwd_o},
                      {47'h0, e.op, e.src, e.hop, e.is_local, e.is_fwd});
            end
        end
    end

    task automatic beat(input logic [63:0] d, input logic last);
        rx_tvalid_i = 1'b1;
        rx_tdata_i  = d;
        rx_tlast_i  = last;
        @(posedge c_clk_i);
        #1;
        rx_tvalid_i = 1'b0;
        rx_tlast_i  = 1'b0;
    endtask

    task automatic build(input logic [4:0] op, input logic [4:0] dst, input logic [4:0] src,
                         input logic [4:0] hop, input logic [31:0] dt1, input logic [31:0] dt2,
                         input logic [31:0] dt3, input logic [47:0] ts, input logic [15:0] flip,
                         output logic [63:0] w0, output logic [63:0] w1, output logic [63:0] w2);
        logic [15:0] cs;
        w0 = {4'hA, op, dst, src, hop, 8'h5C, dt1};
        w1 = {dt2, dt3};
        cs = w0[63:48] ^ w0[47:32] ^ w0[31:16] ^ w0[15:0]
           ^ w1[63:48] ^ w1[47:32] ^ w1[31:16] ^ w1[15:0]
           ^ ts[47:32] ^ ts[31:16] ^ ts[15:0];
        w2 = {ts, cs ^ flip};
    endtask

    task automatic send(input logic [4:0] op, input logic [4:0] dst, input logic [4:0] src,
                        input logic [4:0] hop, input logic [31:0] dt1, input logic [47:0] ts,
                        input logic [15:0] flip, input logic clr_on_last);
        logic [63:0] w0, w1, w2;
        build(op, dst, src, hop, dt1, 32'h0BADF00D, 32'h1, ts, flip, w0, w1, w2);
        beat(w0, 1'b0);
        beat(w1, 1'b0);
        clr_cnt_i = clr_on_last;
        beat(w2, 1'b1);
        clr_cnt_i = 1'b0;
    endtask

    task automatic expect_pkt(input logic [4:0] op, input logic [4:0] src, input logic [4:0] hop,
                              input logic [31:0] dt1, input logic [47:0] ts,
                              input logic loc, input logic fwd);
        exp_t e;
        e.op = op; e.src = src; e.hop = hop; e.dt1 = dt1; e.dt2 = 32'h0BADF00D;
        e.dt3 = 32'h1; e.tstamp = ts; e.is_local = loc; e.is_fwd = fwd;
        sb.push_back(e);
    endtask

    task automatic check_cnts(input string tag);
        check({tag, "_cnt_ok"},   {48'h0, cnt_ok_o},      e_ok);
        check({tag, "_cnt_frm"},  {48'h0, cnt_frm_err_o}, e_frm);
        check({tag, "_cnt_sum"},  {48'h0, cnt_sum_err_o}, e_sum);
        check({tag, "_cnt_drop"}, {48'h0, cnt_drop_o},    e_drop);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_valid"}, {63'h0, pkt_valid_o}, 64'h0);
        check({tag, "_payload"}, {pkt_dt1_o, pkt_dt2_o} | {16'h0, pkt_time_o} | {32'h0, pkt_dt3_o}, 64'h0);
        check({tag, "_flags"}, {49'h0, pkt_op_o, pkt_src_o, pkt_hop_o}, {62'h0, pkt_local_o, pkt_fwd_o});
        e_ok = 0; e_frm = 0; e_sum = 0; e_drop = 0;
        check_cnts(tag);
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 60 && sb.size() != 0; i++)
            @(posedge c_clk_i);
        #1;
        check({tag, "_drained"}, 64'(sb.size()), 64'h0);
    endtask

    task automatic pulse_clr();
        clr_cnt_i = 1'b1;
        @(posedge c_clk_i);
        #1;
        clr_cnt_i = 1'b0;
        e_ok = 0; e_frm = 0; e_sum = 0; e_drop = 0;
    endtask

    initial begin
        logic [63:0] w0, w1, w2;
        repeat (3) @(posedge c_clk_i);
        #1;
        c_rst_i = 1'b0;
        check_outputs_zero("reset");

        // Good local packet: valid one cycle after the W2 edge.
        expect_pkt(5'd4, 5'd1, 5'd0, 32'h12345678, 48'h100, 1'b1, 1'b0);
        send(5'd4, 5'd3, 5'd1, 5'd0, 32'h12345678, 48'h100, 16'h0, 1'b0);
        check("good_valid_latency", {63'h0, pkt_valid_o}, 64'h1);
        drain("good");
        e_ok = 1;
        check_cnts("good");

        // Corrupted checksum.
        pulse_clr();
        send(5'd4, 5'd3, 5'd1, 5'd0, 32'h12345678, 48'h100, 16'h0001, 1'b0);
        check("badsum_no_valid", {63'h0, pkt_valid_o}, 64'h0);
        repeat (2) @(posedge c_clk_i);
        #1;
        e_sum = 1;
        check_cnts("badsum");

        // tlast on W1, then a good packet.
        pulse_clr();
        build(5'd4, 5'd3, 5'd1, 5'd0, 32'h11111111, 32'h0BADF00D, 32'h1, 48'h200, 16'h0, w0, w1, w2);
        beat(w0, 1'b0);
        beat(w1, 1'b1);
        expect_pkt(5'd6, 5'd2, 5'd0, 32'h22222222, 48'h300, 1'b1, 1'b0);
        send(5'd6, 5'd3, 5'd2, 5'd0, 32'h22222222, 48'h300, 16'h0, 1'b0);
        drain("shortpkt");
        e_frm = 1; e_ok = 1;
        check_cnts("shortpkt");

        // Five back-to-back packets into a 4-deep FIFO with the consumer stalled.
        pulse_clr();
        pkt_ready_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (i < 4)
                expect_pkt(5'd1, 5'd1, 5'd0, 32'hA0 + 32'(i), 48'h400 + 48'(i), 1'b1, 1'b0);
            send(5'd1, 5'd3, 5'd1, 5'd0, 32'hA0 + 32'(i), 48'h400 + 48'(i), 16'h0, 1'b0);
        end
        repeat (3) @(posedge c_clk_i);
        #1;
        check("stall_head_stable", {pkt_valid_o, 31'h0, pkt_dt1_o}, {1'b1, 31'h0, 32'hA0});
        e_ok = 4; e_drop = 1;
        check_cnts("full");
        pkt_ready_i = 1'b1;
        drain("full");

        // Broadcast with counter clear colliding with the ok increment: clear wins.
        expect_pkt(5'd2, 5'd1, 5'd3, 32'hB0, 48'h500, 1'b1, 1'b1);
        send(5'd2, 5'h1F, 5'd1, 5'd2, 32'hB0, 48'h500, 16'h0, 1'b1);
        e_ok = 0; e_frm = 0; e_sum = 0; e_drop = 0;
        // Forward-only, hop-limit drop, and loop-return drop.
        expect_pkt(5'd2, 5'd1, 5'd3, 32'hB1, 48'h501, 1'b0, 1'b1);
        send(5'd2, 5'd7, 5'd1, 5'd2, 32'hB1, 48'h501, 16'h0, 1'b0);
        send(5'd2, 5'd7, 5'd1, 5'd31, 32'hB2, 48'h502, 16'h0, 1'b0);
        send(5'd2, 5'd3, 5'd3, 5'd0, 32'hB3, 48'h503, 16'h0, 1'b0);
        drain("route");
        e_ok = 1; e_drop = 2;
        check_cnts("route");

        // Reset lands right after W0; the leftover beats hit the framing-error path.
        build(5'd4, 5'd3, 5'd1, 5'd0, 32'h12345678, 32'h0BADF00D, 32'h1, 48'h100, 16'h0, w0, w1, w2);
        beat(w0, 1'b0);
        c_rst_i = 1'b1;
        @(posedge c_clk_i);
        #1;
        c_rst_i = 1'b0;
        check_outputs_zero("midreset");
        beat(w1, 1'b0);
        beat(w2, 1'b1);
        check("midreset_no_valid", {63'h0, pkt_valid_o}, 64'h0);
        expect_pkt(5'd5, 5'd1, 5'd0, 32'hC0, 48'h600, 1'b1, 1'b0);
        send(5'd5, 5'd3, 5'd1, 5'd0, 32'hC0, 48'h600, 16'h0, 1'b0);
        drain("midreset");
        e_frm = 1; e_ok = 1;
        check_cnts("midreset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
